mem_req_link_arbiter: RTL

Shares the 2-lane memory request serial link between two internal requesters: the cache miss-fill path (req0) and the writeback path (req1). Arbitrates round-robin and latches the winning parallel packet. Shifts the packet out LSB-first, two bits per cycle, on link_data[1:0]. link_valid[1:0] frames each beat. Outputs drive the memory_request_serial_0/1 and memory_request_serial_ready_0/1 pad nets directly.

---
 rtl/mem_req_link_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_req_link_arbiter.sv
// rtl/mem_req_link_arbiter.sv - round-robin arbiter serializing two request streams onto a 2-lane link
module mem_req_link_arbiter #(
  parameter int PKT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [PKT_W-1:0] req0_packet,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [PKT_W-1:0] req1_packet,
  output logic             req1_ready,
  input  logic             link_hold,
  output logic [1:0]       link_data,
  output logic [1:0]       link_valid,
  output logic             busy,
  output logic             grant_id
);

  localparam int BEATS = PKT_W / 2;
  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PKT_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_grant_q, last_grant_d;
  logic               grant_id_q, grant_id_d;
  logic [1:0]         link_data_q, link_data_d;
  logic [1:0]         link_valid_q, link_valid_d;
  logic               busy_q, busy_d;
  logic               grant;
  logic               accept;

  // Round-robin pick: a lone requester always wins, a tie goes to the one not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
    req0_ready = (state_q == IDLE) && !grant && req0_valid && !reset;
    req1_ready = (state_q == IDLE) &&  grant && req1_valid && !reset;
    accept     = req0_ready || req1_ready;
  end

  // Next-state and next-output logic; the link lanes default to an idle 00 beat.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    link_data_d  = 2'b00;
    link_valid_d = 2'b00;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = SEND;
          shift_d      = grant ? req1_packet : req0_packet;
          cnt_d        = '0;
          last_grant_d = grant;
          grant_id_d   = grant;
        end
      end
      SEND: begin
        if (!link_hold) begin
          link_data_d  = shift_q[1:0];
          link_valid_d = 2'b11;
          shift_d      = shift_q >> 2;
          cnt_d        = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any packet in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      link_data_q  <= 2'b00;
      link_valid_q <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      link_data_q  <= link_data_d;
      link_valid_q <= link_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign link_data  = link_data_q;
  assign link_valid = link_valid_q;
  assign busy       = busy_q;
  assign grant_id   = grant_id_q;

endmodule
